// File: rtl/ife_pkg.sv
// Shared IFE constants and types: image geometry, pixel/window types and the window-fetch state enum.
// Used by the window fetcher, the filter core and the result writer.
package ife_pkg;

  localparam int unsigned IMG_W = 128;
  localparam int unsigned IMG_H = 128;
  localparam int unsigned AW    = 14;
  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = $clog2(IMG_W + 1);
  localparam int unsigned RW    = $clog2(IMG_H + 1);
  localparam int unsigned LBW   = $clog2(IMG_W);

  typedef logic [DW-1:0] pixel_t;

  localparam pixel_t PAD_VAL = '0;

  // Element 0 is top-left, element 8 bottom-right, row-major.
  typedef logic [8:0][DW-1:0] win_t;

  typedef enum logic [1:0] {IDLE, FETCH, CAPT, OUT} wf_state_t;

  function automatic logic [AW-1:0] lin_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
    logic [31:0] t;
    t = 32'(row) * IMG_W + 32'(col);
    return t[AW-1:0];
  endfunction

endpackage

// File: rtl/ife_line_buf.sv
// Two IMG_W-deep line buffers indexed by column; a write pushes the new pixel into line 0
// and moves the old line-0 pixel into line 1, both read combinationally before the write.
module ife_line_buf
  import ife_pkg::*;
(
  input  logic           clk,
  input  logic           we,
  input  logic [LBW-1:0] col,
  input  pixel_t         din,
  output pixel_t         q0,
  output pixel_t         q1
);

  pixel_t lb0 [IMG_W];
  pixel_t lb1 [IMG_W];

  assign q0 = lb0[col];
  assign q1 = lb1[col];

  always_ff @(posedge clk) begin
    if (we) begin
      lb0[col] <= din;
      lb1[col] <= lb0[col];
    end
  end

endmodule

// File: rtl/ife_win_fetch.sv
// Raster-scans the image ROM and emits zero-padded 3x3 windows with centre address over valid/ready.
// Optional IFE_WIN_STALL_CNT_EN adds a saturating stall_cnt output.
//
// state | meaning
// IDLE  | waiting for ready, busy low
// FETCH | drive iaddr for grid point (r,c)
// CAPT  | sample idata, update line buffers and window, maybe emit
// OUT   | hold window until win_ready
module ife_win_fetch
  import ife_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ready,
  output logic            busy,
  output logic [AW-1:0]   iaddr,
  input  logic [DW-1:0]   idata,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*DW-1:0] win_pix,
  output logic [AW-1:0]   win_addr,
  output logic            win_last
`ifdef IFE_WIN_STALL_CNT_EN
  ,
  output logic [23:0]     stall_cnt
`endif
);

  wf_state_t      state;
  logic [RW-1:0]  r, r_nxt;
  logic [CW-1:0]  c, c_nxt;
  win_t           win, win_nxt;
  pixel_t         p, top, mid, q0, q1;
  logic           col_ok, in_img, lb_we, emit;

  assign col_ok = c < CW'(IMG_W);
  assign in_img = col_ok && (r < RW'(IMG_H));
  assign lb_we  = (state == CAPT) && col_ok;
  assign emit   = (r != '0) && (c != '0);

  ife_line_buf u_lb (
    .clk (clk),
    .we  (lb_we),
    .col (c[LBW-1:0]),
    .din (p),
    .q0  (q0),
    .q1  (q1)
  );

  always_comb begin
    p   = in_img ? idata : PAD_VAL;
    top = (col_ok && r >= RW'(2)) ? q1 : PAD_VAL;
    mid = (col_ok && r >= RW'(1)) ? q0 : PAD_VAL;
    win_nxt = win;
    // Column 0 starts a fresh row, so the two left columns are padding rather than stale data.
    for (int i = 0; i < 3; i++) begin
      win_nxt[3*i]   = (c == '0) ? PAD_VAL : win[3*i+1];
      win_nxt[3*i+1] = (c == '0) ? PAD_VAL : win[3*i+2];
    end
    win_nxt[2] = top;
    win_nxt[5] = mid;
    win_nxt[8] = p;
    c_nxt = c + 1'b1;
    r_nxt = r;
    if (c == CW'(IMG_W)) begin
      c_nxt = '0;
      r_nxt = r + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      iaddr     <= '0;
      win_valid <= 1'b0;
      win_pix   <= '0;
      win_addr  <= '0;
      win_last  <= 1'b0;
      win       <= '0;
      r         <= '0;
      c         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ready) begin
            busy  <= 1'b1;
            r     <= '0;
            c     <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (in_img) iaddr <= lin_addr(r, c);
          state <= CAPT;
        end
        CAPT: begin
          win <= win_nxt;
          if (emit) begin
            win_pix   <= win_nxt;
            win_addr  <= lin_addr(RW'(r - 1'b1), CW'(c - 1'b1));
            win_last  <= (r == RW'(IMG_H)) && (c == CW'(IMG_W));
            win_valid <= 1'b1;
            state     <= OUT;
          end else begin
            r     <= r_nxt;
            c     <= c_nxt;
            state <= FETCH;
          end
        end
        OUT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            if (win_last) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              r     <= r_nxt;
              c     <= c_nxt;
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFE_WIN_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (state == IDLE && ready)
      stall_cnt <= '0;
    else if (state == OUT && !win_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ife_win_fetch.sv
// Scoreboard bench for ife_win_fetch: a window-level image model fills the expected queue,
// a monitor pops on every handshake; covers reset, throttling, frame end, mid-frame abort and restart.
module tb_ife_win_fetch;
  import ife_pkg::*;

  localparam int W    = int'(IMG_W);
  localparam int H    = int'(IMG_H);
  localparam int NPIX = W * H;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            ready = 1'b0;
  logic            busy;
  logic [AW-1:0]   iaddr;
  logic [DW-1:0]   idata;
  logic            win_valid;
  logic            win_ready = 1'b0;
  logic [9*DW-1:0] win_pix;
  logic [AW-1:0]   win_addr;
  logic            win_last;
`ifdef IFE_WIN_STALL_CNT_EN
  logic [23:0]     stall_cnt;
`endif

  logic [DW-1:0] rom [NPIX];
  assign idata = rom[iaddr];

  typedef struct packed {
    logic [9*DW-1:0] pix;
    logic [AW-1:0]   addr;
    logic            last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   popped = 0;
  int   stall_seen = 0;
  int   throttle_pct = 100;
  int   img_kind = 0;

  localparam logic [9*DW-1:0] RCOL_MASK = {8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};

  ife_win_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .ready     (ready),
    .busy      (busy),
    .iaddr     (iaddr),
    .idata     (idata),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_pix   (win_pix),
    .win_addr  (win_addr),
    .win_last  (win_last)
`ifdef IFE_WIN_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic logic [9*DW-1:0] ref_win(input int y, input int x);
    logic [9*DW-1:0] w;
    int yy, xx;
    w = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        yy = y + dy;
        xx = x + dx;
        if (yy >= 0 && yy < H && xx >= 0 && xx < W)
          w[((dy+1)*3 + dx + 1)*DW +: DW] = rom[yy*W + xx];
        else
          w[((dy+1)*3 + dx + 1)*DW +: DW] = PAD_VAL;
      end
    end
    return w;
  endfunction

  task automatic push_frame();
    exp_t e;
    exp_q.delete();
    for (int a = 0; a < NPIX; a++) begin
      e.pix  = ref_win(a / W, a % W);
      e.addr = AW'(a);
      e.last = (a == NPIX - 1);
      exp_q.push_back(e);
    end
  endtask

  initial begin : throttle
    forever begin
      @(posedge clk);
      #1;
      win_ready = ($urandom_range(99) < throttle_pct);
    end
  end

  initial begin : monitor
    logic            pv;
    logic            chk_busy;
    logic [9*DW-1:0] ppix;
    logic [AW-1:0]   paddr;
    logic            plast;
    exp_t            e;
    pv = 1'b0;
    chk_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pv = 1'b0;
        chk_busy = 1'b0;
      end else begin
        if (chk_busy) begin
          check("busy_fall", busy, 1'b0);
          chk_busy = 1'b0;
        end
        if (pv)
          check("stall_hold", {win_valid, win_pix, win_addr, win_last}, {1'b1, ppix, paddr, plast});
        pv = 1'b0;
        if (win_valid && win_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_win", {1'b1, win_addr}, 0);
          end else begin
            e = exp_q.pop_front();
            check("win_addr", win_addr, e.addr);
            check("win_pix", win_pix, e.pix);
            check("win_last", win_last, e.last);
            popped++;
            if (img_kind == 0 && win_addr == 0)
              check("const_a0", win_pix, {8'h55, 8'h55, 8'h00, 8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00});
            if (img_kind == 0 && win_addr == 645)
              check("const_a645", win_pix, {9{8'h55}});
            if (img_kind == 0 && win_addr == AW'(NPIX - 1))
              check("const_alast", win_pix, {8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h55, 8'h00, 8'h55, 8'h55});
            if (img_kind == 1 && win_addr == 129)
              check("ramp_a129", win_pix, {8'h02, 8'h01, 8'h00, 8'h82, 8'h81, 8'h80, 8'h02, 8'h01, 8'h00});
            if (img_kind == 1 && win_addr == 127)
              check("ramp_a127_rcol", win_pix & RCOL_MASK, 0);
            if (win_last) begin
              check("busy_at_last", busy, 1'b1);
              chk_busy = 1'b1;
            end
          end
        end else if (win_valid) begin
          pv = 1'b1;
          ppix = win_pix;
          paddr = win_addr;
          plast = win_last;
          stall_seen++;
        end
      end
    end
  end

  initial begin : main
    int cyc;
    // Frame A: ramp image, throttled, aborted by reset mid-frame.
    reset = 1'b0;
    ready = 1'b1;
    img_kind = 1;
    throttle_pct = 30;
    for (int a = 0; a < NPIX; a++) rom[a] = DW'(a);
    push_frame();
    repeat (4) begin
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_valid", win_valid, 1'b0);
      check("rst_iaddr", iaddr, 0);
    end
    check("rst_pix", {win_pix, win_addr, win_last}, 0);
    #1 reset = 1'b1;
    check("busy_pre_edge", busy, 1'b0);
    @(negedge clk);
    check("busy_rise", busy, 1'b1);
    ready = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk);
      #2;
      cyc++;
    end while (!(popped >= 600 && win_valid) && cyc < 20000);
    check("frameA_reach_out", cyc < 20000, 1'b1);
`ifdef IFE_WIN_STALL_CNT_EN
    check("stall_cnt_A", stall_cnt, stall_seen);
`endif
    reset = 1'b0;
    #1;
    check("abort_valid", win_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_pix", win_pix, 0);
    check("abort_addr", win_addr, 0);
    check("abort_last", win_last, 1'b0);
    check("abort_iaddr", iaddr, 0);
    exp_q.delete();
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_abort", busy, 1'b0);

    // Frame B: constant 0x55, unthrottled, full frame with a stray ready pulse mid-frame.
    for (int a = 0; a < NPIX; a++) rom[a] = 8'h55;
    img_kind = 0;
    throttle_pct = 100;
    push_frame();
    popped = 0;
    stall_seen = 0;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("busy_start_B", busy, 1'b1);
    cyc = 0;
    while (busy && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 20000) ready = 1'b1;
      else if (cyc == 20003) ready = 1'b0;
    end
    check("frameB_done", busy, 1'b0);
    check("frameB_count", popped, NPIX);
    check("frameB_q_empty", exp_q.size(), 0);
`ifdef IFE_WIN_STALL_CNT_EN
    check("stall_cnt_B", stall_cnt, stall_seen);
`endif

    // Frame C: random image, throttled, restart from address 0.
    for (int a = 0; a < NPIX; a++) rom[a] = DW'($urandom);
    img_kind = 2;
    throttle_pct = 30;
    push_frame();
    popped = 0;
    stall_seen = 0;
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("busy_start_C", busy, 1'b1);
    cyc = 0;
    do begin
      @(posedge clk);
      #2;
      cyc++;
    end while (!(popped >= 300 && win_valid) && cyc < 10000);
    check("frameC_progress", cyc < 10000, 1'b1);
`ifdef IFE_WIN_STALL_CNT_EN
    check("stall_cnt_C", stall_cnt, stall_seen);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
